// File: rtl/tem_pkg.sv
// Shared types and constants for the temperature BCD conversion stage.
package tem_pkg;

    localparam int TEM_W      = 16;
    localparam int BCD_DIGITS = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [7:0] SEG_DIGIT [0:9] = '{
        8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66,
        8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F
    };
    localparam logic [7:0] SEG_MINUS = 8'h40;
    localparam logic [7:0] SEG_BLANK = 8'h00;

    // Double-dabble correction: every digit >= 5 gets +3 before the shift.
    function automatic logic [4*BCD_DIGITS-1:0] dabble_adjust(input logic [4*BCD_DIGITS-1:0] s);
        logic [4*BCD_DIGITS-1:0] r;
        r = s;
        for (int i = 0; i < BCD_DIGITS; i++) begin
            if (s[4*i +: 4] >= 4'd5) begin
                r[4*i +: 4] = s[4*i +: 4] + 4'd3;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/tem_bcd_conv_seg7_dec.sv
// BCD digit to TM1638 common-cathode segment byte (bit0=a .. bit6=g, dp=0).
module seg7_dec
    import tem_pkg::*;
(
    input  logic [3:0] bcd_digit,
    output logic [7:0] seg_byte
);

    always_comb begin
        seg_byte = SEG_BLANK;
        if (bcd_digit <= 4'd9) begin
            seg_byte = SEG_DIGIT[bcd_digit];
        end
    end

endmodule

// File: rtl/tem_bcd_conv.sv
// Signed 16-bit temperature to sign + 5 BCD digits, one bit per clock (double dabble).
// Optional TM1638 segment output enabled by defining TEM_BCD_SEG_EN.
module tem_bcd_conv
    import tem_pkg::*;
#(
    parameter int IN_W   = TEM_W,
    parameter int DIGITS = BCD_DIGITS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [IN_W-1:0]       tem_bin,
    output logic                  busy,
    output logic                  done,
    output logic                  neg,
    output logic [4*DIGITS-1:0]   bcd
`ifdef TEM_BCD_SEG_EN
    ,
    output logic [47:0]           seg
`endif
);

    state_t                state_q, state_d;
    logic [IN_W-1:0]       mag_q, mag_d;
    logic [4*DIGITS-1:0]   scratch_q, scratch_d;
    logic [3:0]            cnt_q, cnt_d;
    logic                  neg_r_q, neg_r_d;
    logic                  neg_q, neg_d;
    logic [4*DIGITS-1:0]   bcd_q, bcd_d;

    logic [4*DIGITS-1:0]   adj;
    logic [4*DIGITS-1:0]   shifted;

    assign adj     = dabble_adjust(scratch_q);
    assign shifted = {adj[4*DIGITS-2:0], mag_q[IN_W-1]};

`ifdef TEM_BCD_SEG_EN
    logic [47:0] seg_q, seg_d;
    logic [47:0] seg_next;
    logic [7:0]  dec_byte [0:4];
    logic [2:0]  msd;

    genvar g;
    generate
        for (g = 0; g < 5; g++) begin : g_dec
            seg7_dec u_dec (
                .bcd_digit (shifted[4*g +: 4]),
                .seg_byte  (dec_byte[g])
            );
        end
    endgenerate

    // Blank leading zeros; the minus sign sits just left of the top shown digit.
    always_comb begin
        msd = 3'd0;
        for (int k = 1; k < 5; k++) begin
            if (shifted[4*k +: 4] != 4'd0) begin
                msd = 3'(k);
            end
        end
        seg_next = '0;
        for (int k = 0; k < 6; k++) begin
            seg_next[8*k +: 8] = SEG_BLANK;
            if (k < 5 && 3'(k) <= msd) begin
                seg_next[8*k +: 8] = dec_byte[k];
            end else if (3'(k) == msd + 3'd1 && neg_r_q) begin
                seg_next[8*k +: 8] = SEG_MINUS;
            end
        end
    end
`endif

    always_comb begin
        state_d   = state_q;
        mag_d     = mag_q;
        scratch_d = scratch_q;
        cnt_d     = cnt_q;
        neg_r_d   = neg_r_q;
        neg_d     = neg_q;
        bcd_d     = bcd_q;
`ifdef TEM_BCD_SEG_EN
        seg_d     = seg_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    mag_d     = tem_bin[IN_W-1] ? (~tem_bin + 16'd1) : tem_bin;
                    neg_r_d   = tem_bin[IN_W-1];
                    scratch_d = '0;
                    cnt_d     = 4'd0;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                scratch_d = shifted;
                mag_d     = {mag_q[IN_W-2:0], 1'b0};
                cnt_d     = cnt_q + 4'd1;
                if (cnt_q == 4'd15) begin
                    bcd_d   = shifted;
                    neg_d   = neg_r_q;
`ifdef TEM_BCD_SEG_EN
                    seg_d   = seg_next;
`endif
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            mag_q     <= '0;
            scratch_q <= '0;
            cnt_q     <= '0;
            neg_r_q   <= 1'b0;
            neg_q     <= 1'b0;
            bcd_q     <= '0;
`ifdef TEM_BCD_SEG_EN
            seg_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            mag_q     <= mag_d;
            scratch_q <= scratch_d;
            cnt_q     <= cnt_d;
            neg_r_q   <= neg_r_d;
            neg_q     <= neg_d;
            bcd_q     <= bcd_d;
`ifdef TEM_BCD_SEG_EN
            seg_q     <= seg_d;
`endif
        end
    end

    assign busy = (state_q != IDLE);
    assign done = (state_q == DONE);
    assign neg  = neg_q;
    assign bcd  = bcd_q;
`ifdef TEM_BCD_SEG_EN
    assign seg  = seg_q;
`endif

endmodule

// File: doc/tem_bcd_conv.md
Name: tem_bcd_conv

Overview:
Downstream stage of the temperature datapath. It takes the signed 16-bit integer temperature word tem_bin (two's complement, degrees C) and converts it to sign plus 5 BCD digits using a sequential shift-add-3 (double-dabble) engine. Its output feeds the TM1638 display driver. Conversion runs one bit per clock under a start/busy/done handshake.

Parameters:
IN_W, 16, input word width; fixed at 16 for this revision.
DIGITS, 5, BCD digits produced; must hold |−32768| = 32768.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous reset, active-high
start  input  1  conversion request; accepted only in IDLE
tem_bin  input  16  signed temperature integer (two's complement)
busy  output  1  high whenever state != IDLE
done  output  1  one-cycle pulse; result valid and updated
neg  output  1  sign of last converted value (1 = negative)
bcd  output  20  digits: [3:0] ones, [7:4] tens, … [19:16] ten-thousands

Behaviour:
- Interface (already decided): one clock, clk; reset rst is synchronous and active-high.
- Reset (rst=1 at a clk edge): state=IDLE, busy=0, done=0, neg=0, bcd=0, internal shift and counter registers cleared. Reset wins over any other event, including mid-conversion: the conversion is aborted, no done is produced, and outputs are zeroed.
- FSM states: IDLE, SHIFT, DONE.
- IDLE: start=1 at edge N
  - captures mag = tem_bin[15] ? (~tem_bin + 1) : tem_bin, as 16-bit unsigned; 0x8000 yields 32768.
  - captures neg_r = tem_bin[15], clears the BCD scratch and bit counter, and goes to SHIFT.
- SHIFT: at each edge, every scratch digit ≥ 5 gets +3, then {scratch, mag} shifts left by 1. Exactly 16 edges (N+1 … N+16); the counter goes 0..15.
  - On the 16th edge: bcd ← final scratch, neg ← neg_r, state goes to DONE.
- DONE: done=1 for exactly one cycle, then IDLE at the next edge.
- Timing: start sampled at edge N; done is high in the cycle after edge N+16; bcd/neg change only at that same edge. Throughput is one conversion per 18 cycles.
- start while busy (SHIFT or DONE) is ignored and not queued. tem_bin changes while busy have no effect.
- bcd/neg hold their value between conversions.
- Zero input: bcd=0, neg=0. Negative zero cannot occur.
- Each digit is always ≤ 9. Scratch width is 20 bits, so no overflow is possible.

Optional Feature:
Macro TEM_BCD_SEG_EN.
- Defined: extra output seg [47:0], six TM1638 segment bytes, common-cathode. Bit0=a … bit6=g, bit7=dp=0. Byte k (bits 8k+7:8k) is position k, with pos0 = ones.
  - Digit codes 0–9: 3F 06 5B 4F 66 6D 7D 07 7F 6F.
  - Leading zeros are blanked to 0x00; pos0 is never blanked.
  - If neg=1, minus 0x40 goes in the first position left of the most-significant displayed digit; pos5 is used only for −10000…−32768.
  - seg is registered and updated at the same edge as bcd. Its reset value is 0.
- Undefined: the seg port and its logic are absent. All other behaviour is identical.

Decomposition:
- Shared package tem_pkg:
  - state enum {IDLE, SHIFT, DONE}
  - TEM_W=16 and BCD_DIGITS=5 constants
  - SEG_DIGIT[0:9] table, SEG_MINUS=8'h40, SEG_BLANK=8'h00
- One natural sub-module: seg7_dec (4-bit BCD → 8-bit segment byte, combinational). It is instantiated 5× under TEM_BCD_SEG_EN only.

Test Plan:
- rst=1 for 2 cycles, then tem_bin=25, start pulse → done exactly 17 cycles after the start edge. Expect bcd=20'h00025, neg=0; with TEM_BCD_SEG_EN, seg=48'h0000_0000_5B6D.
- tem_bin=16'hFFD3 (−45), start → bcd=20'h00045, neg=1; seg pos0=6D, pos1=66, pos2=40, pos3..5=00.
- tem_bin=16'h8000 → bcd=20'h32768, neg=1, seg pos5=40. Then tem_bin=16'h7FFF → bcd=20'h32767, neg=0.
- tem_bin=0, start → bcd=0, neg=0, seg pos0=3F and all other positions 00.
- Start 130, then pulse start again with tem_bin=99 at cycles +3 and +17 (DONE) → single done, bcd=20'h00130. A start issued in IDLE afterwards yields 00099.
- Start −45, assert rst at cycle +8 → no done pulse, busy=0 the cycle after, bcd=0, neg=0. A new start then converts normally.
